// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO with registered outputs; no combinational path from inputs to outputs.
// Optional occupancy output is enabled by defining HANDSHAKE_FIFO_COUNT_EN.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef HANDSHAKE_FIFO_COUNT_EN
  ,
  output logic [CNT_W-1:0]      occupancy
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Ready and valid depend only on the occupancy register, which breaks the ready chain.
  assign ins_ready  = !full;
  assign outs_valid = !empty;
  assign outs       = mem_q[rd_ptr_q];

  assign push = ins_valid && ins_ready;
  assign pop  = outs_valid && outs_ready;

`ifdef HANDSHAKE_FIFO_COUNT_EN
  assign occupancy = count_q;
`endif

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = ins;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is reset on purpose so outs reads 0 while empty after reset.
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Randomized and directed bench for handshake_fifo_buffer against a queue-based reference model.
module tb_handshake_fifo_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] ins = '0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready = 1'b0;
`ifdef HANDSHAKE_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] occupancy;
`endif

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
`ifdef HANDSHAKE_FIFO_COUNT_EN
    ,
    .occupancy  (occupancy)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: tokens currently queued, and every token accepted since reset.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] hist[$];
  bit            last_push;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // While empty the head slot is the one written DEPTH pushes ago, or 0 if never written.
  function automatic logic [DW-1:0] exp_outs();
    if (model_q.size() > 0) return model_q[0];
    if (hist.size() >= DEPTH) return hist[hist.size() - DEPTH];
    return '0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".outs_valid"}, 32'(outs_valid), 32'(model_q.size() > 0));
    check({tag, ".ins_ready"},  32'(ins_ready),  32'(model_q.size() < DEPTH));
    check({tag, ".outs"},       32'(outs),       32'(exp_outs()));
`ifdef HANDSHAKE_FIFO_COUNT_EN
    check({tag, ".occupancy"},  32'(occupancy),  32'(model_q.size()));
`endif
  endtask

  // Drive one cycle of stimulus after a negedge, advance the model at posedge, check at negedge.
  task automatic step(input string tag, input bit v, input logic [DW-1:0] d, input bit r);
    bit pushed, popped;
    ins        = d;
    ins_valid  = v;
    outs_ready = r;
    pushed = v && (model_q.size() < DEPTH);
    popped = r && (model_q.size() > 0);
    @(posedge clk);
    if (popped) void'(model_q.pop_front());
    if (pushed) begin
      model_q.push_back(d);
      hist.push_back(d);
    end
    last_push = pushed;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    hist.delete();
  endtask

  initial begin
    // Reset then idle
    repeat (3) @(negedge clk);
    check_outputs("in_reset");
    rst = 1'b1;
    @(negedge clk);
    check_outputs("after_reset");

    // Single token, visible exactly one cycle later, then gone
    step("single_push", 1'b1, 16'h0005, 1'b1);
    check("single_outs", 32'(outs), 32'h0005);
    step("single_pop", 1'b0, 16'h0000, 1'b1);
    check("single_empty", 32'(outs_valid), 32'h0);

    // Fill to full with consumer stalled; 0x55 must be held off
    step("fill0", 1'b1, 16'h0011, 1'b0);
    step("fill1", 1'b1, 16'h0022, 1'b0);
    step("fill2", 1'b1, 16'h0033, 1'b0);
    step("fill3", 1'b1, 16'h0044, 1'b0);
    check("full_ready_low", 32'(ins_ready), 32'h0);
    step("blocked0", 1'b1, 16'h0055, 1'b0);
    step("blocked1", 1'b1, 16'h0055, 1'b0);
    check("full_head", 32'(outs), 32'h0011);

    // Drain in order
    step("drain0", 1'b0, 16'h0000, 1'b1);
    check("drain0_ready_back", 32'(ins_ready), 32'h1);
    check("drain0_head", 32'(outs), 32'h0022);
    step("drain1", 1'b0, 16'h0000, 1'b1);
    step("drain2", 1'b0, 16'h0000, 1'b1);
    step("drain3", 1'b0, 16'h0000, 1'b1);
    check("drained_empty", 32'(outs_valid), 32'h0);

    // Streaming 10 tokens at one per cycle; pointers wrap
    for (int i = 0; i < 10; i++) begin
      step($sformatf("stream%0d", i), 1'b1, DW'(i), 1'b1);
      check($sformatf("stream%0d_head", i), 32'(outs), 32'(i));
    end
    step("stream_tail", 1'b0, 16'h0000, 1'b1);
    check("stream_done", 32'(outs_valid), 32'h0);

    // Reset mid-stream with three tokens queued
    step("pre_rst0", 1'b1, 16'h0001, 1'b0);
    step("pre_rst1", 1'b1, 16'h0002, 1'b0);
    step("pre_rst2", 1'b1, 16'h0003, 1'b0);
    ins_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("async_rst.outs_valid", 32'(outs_valid), 32'h0);
    check("async_rst.ins_ready",  32'(ins_ready),  32'h1);
    check("async_rst.outs",       32'(outs),       32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs("post_rst");
    step("post_rst_push", 1'b1, 16'h00AA, 1'b0);
    check("post_rst_first", 32'(outs), 32'h00AA);
    step("post_rst_pop", 1'b0, 16'h0000, 1'b1);

    // Randomized traffic; producer holds its token until accepted
    begin
      bit            v = 1'b0;
      logic [DW-1:0] d = '0;
      last_push = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (!v || last_push) begin
          v = ($urandom_range(0, 3) != 0);
          d = DW'($urandom);
        end
        step("rand", v, d, ($urandom_range(0, 2) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
